pulse_gen: RTL and testbench
============================

# pulse_gen

Programmable trigger-pulse train generator: the source side of the trigger path whose pulses are consumed downstream by the first-pulse inhibit stage. On a start request it waits a programmable delay, then emits a programmable number of fixed-width pulses at a fixed period on `POUT`. It raises `DONE` when the train completes. It sits in the timing/trigger section and drives `TRG_ONE`-style inputs of downstream pulse logic.

## Interface
- `CW`, 16: width of all delay/width/period/count settings and counters.
- `CLK`  in  1  system clock; all logic on rising edge.
- `R`  in  1  reset, synchronous, active-high.
- `START`  in  1  level-sampled start request; accepted only in IDLE.
- `STOP`  in  1  abort request; takes effect at the next edge in any state.
- `DELAY`  in  CW  cycles from acceptance to first rising edge of `POUT`.
- `WIDTH`  in  CW  high time per pulse in cycles; 0 treated as 1.
- `PERIOD`  in  CW  rising-edge-to-rising-edge spacing; values < WIDTH+1 clamped to WIDTH+1.
- `COUNT`  in  CW  pulses per train; 0 = continuous until `STOP`.
- `POUT`  out  1  registered pulse output.
- `BUSY`  out  1  high from acceptance until train ends or abort.
- `DONE`  out  1  one-cycle completion strobe; not asserted on abort or reset.
- `PCNT`  out  CW  pulses emitted in current/last train; wraps modulo 2^CW in continuous mode.

## Operation
- States: IDLE, WAIT, HIGH, LOW.
- IDLE: `START`=1 and `STOP`=0 at an edge → settings latched (later input changes ignored), `PCNT` cleared, `BUSY`=1; next state WAIT if DELAY>0, else HIGH.
- WAIT: counts DELAY cycles, then HIGH.
- HIGH: `POUT`=1 for effective WIDTH cycles; `PCNT` increments on entry to HIGH.
- After HIGH: if COUNT≠0 and `PCNT`=COUNT → IDLE with `DONE`=1 for one cycle; else LOW for (effective PERIOD − effective WIDTH) cycles, then HIGH.
- `STOP`=1 in any non-IDLE state → IDLE at that edge, `POUT`=0, `BUSY`=0, `DONE`=0, `PCNT` holds.
- `START` and `STOP` both high in IDLE: `STOP` wins, no start.
- `START` while BUSY: ignored; a held-high `START` re-triggers only after return to IDLE (one cycle idle gap minimum).
- Reset value of every output: `POUT`=0, `BUSY`=0, `DONE`=0, `PCNT`=0; state IDLE. `R` mid-train aborts identically, overriding `STOP`/`START`.

## Timing
- START accepted at edge k: `BUSY` high from edge k.
- First `POUT` rise at edge k+DELAY (DELAY=0: edge k).
- Pulse n (n=0..) rises at k+DELAY+n·P, falls at k+DELAY+n·P+W (P, W effective values).
- Last pulse falls at edge f: `DONE`=1 and `BUSY`=0 from edge f for exactly one cycle of `DONE`.
- Minimum low gap between pulses is 1 cycle, so every pulse is a distinct edge for downstream logic.

## Structure
- Shared package `pulse_gen_pkg`: state enum (IDLE, WAIT, HIGH, LOW), default `CW`.
- One sub-module, `pgen_cnt`: CW-bit loadable down-counter with a zero flag, used for delay/high/low phase timing. `PCNT` is a separate up-counter in the top.

## Test plan
- DELAY=3, WIDTH=2, PERIOD=5, COUNT=3, START at edge 0 → `POUT` high cycles 3-4, 8-9, 13-14; `DONE` at edge 15; `PCNT`=3.
- DELAY=0, WIDTH=0, PERIOD=0, COUNT=2 → `POUT` high edges 0 and 2 (W=1, P=2); `DONE` at edge 3.
- COUNT=0, WIDTH=1, PERIOD=4, `STOP` at edge 10 → pulses at 0, 4, 8; `POUT`=0, `BUSY`=0 from edge 10; no `DONE`.
- Train in progress, `START` pulsed again and settings changed → waveform unchanged.
- `R` during HIGH → all outputs 0 next edge; START+STOP together in IDLE → no start.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the trigger pulse-train generator: FSM state encoding
// and the default settings/counter width.
package pulse_gen_pkg;

  localparam int PG_CW = 16;

  typedef enum logic [1:0] {
    PG_IDLE = 2'd0,
    PG_WAIT = 2'd1,
    PG_HIGH = 2'd2,
    PG_LOW  = 2'd3
  } pg_state_e;

endpackage

// File: rtl/pulse_gen_if.sv
// Control/status bundle between a trigger sequencer (master) and pulse_gen (slave).
interface pulse_gen_if
  import pulse_gen_pkg::*;
#(
  parameter int CW = PG_CW
) ();

  logic          START;
  logic          STOP;
  logic [CW-1:0] DELAY;
  logic [CW-1:0] WIDTH;
  logic [CW-1:0] PERIOD;
  logic [CW-1:0] COUNT;
  logic          POUT;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] PCNT;

  modport master (
    output START, STOP, DELAY, WIDTH, PERIOD, COUNT,
    input  POUT, BUSY, DONE, PCNT
  );

  modport slave (
    input  START, STOP, DELAY, WIDTH, PERIOD, COUNT,
    output POUT, BUSY, DONE, PCNT
  );

endinterface

// File: rtl/pgen_cnt.sv
// Loadable down-counter with zero flag; times the delay, high and low phases.
// A phase of N cycles is timed by loading N-1 and leaving when the flag is set.
module pgen_cnt #(
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (R) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && !zero) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable trigger pulse-train generator: delay, then COUNT pulses of WIDTH
// high cycles every PERIOD cycles on POUT, with BUSY/DONE/PCNT status.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CW = PG_CW
) (
  input  logic        CLK,
  input  logic        R,
  pulse_gen_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = PG_IDLE;
  localparam logic [1:0] ST_WAIT = PG_WAIT;
  localparam logic [1:0] ST_HIGH = PG_HIGH;
  localparam logic [1:0] ST_LOW  = PG_LOW;

  function automatic logic [CW-1:0] eff_width(input logic [CW-1:0] w);
    return (w == '0) ? CW'(1) : w;
  endfunction

  // Low time = effective period - effective width; computed one bit wider so
  // WIDTH = all-ones (period clamps to 2^CW) cannot overflow.
  function automatic logic [CW-1:0] low_len(input logic [CW-1:0] w, input logic [CW-1:0] p);
    logic [CW:0] we;
    logic [CW:0] pe;
    we = {1'b0, eff_width(w)};
    pe = ({1'b0, p} < (we + (CW+1)'(1))) ? (we + (CW+1)'(1)) : {1'b0, p};
    return CW'(pe - we);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] width_q;
  logic [CW-1:0] low_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic          pout_q;
  logic          busy_q;
  logic          done_q, done_d;

  logic          start_ok;
  logic          latch_cfg;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic [CW-1:0] width_in;
  logic          last_pulse;

  assign start_ok   = (state_q == ST_IDLE) && bus.START && !bus.STOP;
  assign width_in   = eff_width(bus.WIDTH);
  assign last_pulse = (count_q != '0) && (pcnt_q == count_q);

  pgen_cnt #(.CW(CW)) u_cnt (
    .CLK      (CLK),
    .R        (R),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (state_q != ST_IDLE),
    .zero     (cnt_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    done_d    = 1'b0;
    latch_cfg = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          latch_cfg = 1'b1;
          cnt_load  = 1'b1;
          if (bus.DELAY != '0) begin
            state_d = ST_WAIT;
            pcnt_d  = '0;
            cnt_val = bus.DELAY - CW'(1);
          end else begin
            state_d = ST_HIGH;
            pcnt_d  = CW'(1);
            cnt_val = width_in - CW'(1);
          end
        end
      end
      ST_WAIT, ST_LOW: begin
        if (cnt_zero) begin
          state_d  = ST_HIGH;
          pcnt_d   = pcnt_q + CW'(1);
          cnt_load = 1'b1;
          cnt_val  = width_q - CW'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          if (last_pulse) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_LOW;
            cnt_load = 1'b1;
            cnt_val  = low_q - CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort: drops to IDLE with no DONE, PCNT keeps its last value.
    if (bus.STOP && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      pcnt_d   = pcnt_q;
      done_d   = 1'b0;
      cnt_load = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      pout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      pout_q  <= (state_d == ST_HIGH);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  // Settings are captured only at acceptance; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (R) begin
      width_q <= CW'(1);
      low_q   <= CW'(1);
      count_q <= '0;
    end else if (latch_cfg) begin
      width_q <= width_in;
      low_q   <= low_len(bus.WIDTH, bus.PERIOD);
      count_q <= bus.COUNT;
    end
  end

  assign bus.POUT = pout_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.PCNT = pcnt_q;

`ifndef SYNTHESIS
  a_pout_busy: assert property (@(posedge CLK) pout_q |-> busy_q);
  a_done_idle: assert property (@(posedge CLK) done_q |-> (!busy_q && !pout_q));
`endif

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: a timing-formula model checked every cycle,
// directed trains pinned by literal waveforms, then randomized traffic.
module tb_pulse_gen;
  import pulse_gen_pkg::*;

  localparam int CW = 16;
  localparam int TR = 8192;

  logic clk;
  logic r;
  int   vectors;
  int   miscompares;
  int   edge_n;

  logic [18:0] tr [0:TR-1];

  pulse_gen_if #(.CW(CW)) bus ();

  pulse_gen #(.CW(CW)) dut (
    .CLK (clk),
    .R   (r),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: once a train is accepted at edge k, every later edge e is
  // evaluated from rel = e-k-D with pulse n occupying rel in [n*P, n*P+W).
  initial begin
    bit     act;
    longint k, d, w, p, c, rel, pc;
    bit     e_pout, e_busy, e_done;
    logic   r_s, start_s, stop_s;
    logic [CW-1:0] dl_s, wd_s, pd_s, ct_s;
    act = 0; k = 0; d = 0; w = 1; p = 2; c = 0; pc = 0;
    e_pout = 0; e_busy = 0; e_done = 0;
    edge_n = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      r_s = r; start_s = bus.START; stop_s = bus.STOP;
      dl_s = bus.DELAY; wd_s = bus.WIDTH; pd_s = bus.PERIOD; ct_s = bus.COUNT;
      #1;
      if (r_s) begin
        act = 0; pc = 0; e_pout = 0; e_busy = 0; e_done = 0;
      end else begin
        e_done = 0;
        if (act && stop_s) begin
          act = 0; e_pout = 0; e_busy = 0;
        end else begin
          if (!act && start_s && !stop_s) begin
            act = 1; k = edge_n; d = dl_s;
            w = (wd_s == 0) ? 1 : longint'(wd_s);
            p = (longint'(pd_s) < w + 1) ? w + 1 : longint'(pd_s);
            c = ct_s;
          end
          if (act) begin
            rel = edge_n - k - d;
            if (c != 0 && rel == (c - 1) * p + w) begin
              act = 0; e_done = 1; e_pout = 0; e_busy = 0;
            end else begin
              e_busy = 1;
              e_pout = (rel >= 0) && ((rel % p) < w);
              pc = (rel < 0) ? 0 : ((rel / p + 1) % 65536);
            end
          end else begin
            e_pout = 0; e_busy = 0;
          end
        end
      end
      if (edge_n < TR) tr[edge_n] = {bus.POUT, bus.BUSY, bus.DONE, bus.PCNT};
      check($sformatf("edge%0d {pout,busy,done,pcnt}", edge_n),
            64'({bus.POUT, bus.BUSY, bus.DONE, bus.PCNT}),
            64'({e_pout, e_busy, e_done, CW'(pc)}));
    end
  end

  function automatic logic [31:0] mask(input int k, input int n, input int bit_sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = tr[k+i][bit_sel];
    return m;
  endfunction

  function automatic logic [CW-1:0] pcnt_at(input int e);
    return tr[e][CW-1:0];
  endfunction

  task automatic start_train(input int d, input int w, input int p, input int c, output int k);
    @(negedge clk);
    bus.DELAY = CW'(d); bus.WIDTH = CW'(w); bus.PERIOD = CW'(p); bus.COUNT = CW'(c);
    bus.START = 1'b1;
    k = edge_n + 1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic check_t1(input int k, input string tag);
    check({tag, "_pout"}, mask(k, 17, 18), 32'h0000_6318);
    check({tag, "_busy"}, mask(k, 17, 17), 32'h0000_7FFF);
    check({tag, "_done"}, mask(k, 17, 16), 32'h0000_8000);
    check({tag, "_pcnt"}, pcnt_at(k + 16), 16'd3);
  endtask

  initial begin
    int k;
    vectors = 0; miscompares = 0;
    r = 1'b1;
    bus.START = 1'b0; bus.STOP = 1'b0;
    bus.DELAY = '0; bus.WIDTH = '0; bus.PERIOD = '0; bus.COUNT = '0;
    repeat (3) @(negedge clk);
    r = 1'b0;
    check("reset_outputs", 64'(tr[3]), 64'd0);

    // Train 1: D=3 W=2 P=5 C=3.
    start_train(3, 2, 5, 3, k);
    repeat (17) @(negedge clk);
    check_t1(k, "t1");

    // Train 2: zero settings clamp to W=1, P=2.
    start_train(0, 0, 0, 2, k);
    repeat (6) @(negedge clk);
    check("t2_pout", mask(k, 6, 18), 32'h05);
    check("t2_busy", mask(k, 6, 17), 32'h07);
    check("t2_done", mask(k, 6, 16), 32'h08);
    check("t2_pcnt", pcnt_at(k + 5), 16'd2);

    // Train 3: continuous, aborted by STOP at edge k+10.
    start_train(0, 1, 4, 0, k);
    repeat (9) @(negedge clk);
    bus.STOP = 1'b1;
    @(negedge clk);
    bus.STOP = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_pout", mask(k, 13, 18), 32'h111);
    check("t3_busy", mask(k, 13, 17), 32'h3FF);
    check("t3_done", mask(k, 13, 16), 32'h0);
    check("t3_pcnt", pcnt_at(k + 12), 16'd3);

    // Train 4: same as train 1 with START re-pulsed and settings scrambled mid-train.
    start_train(3, 2, 5, 3, k);
    @(negedge clk);
    bus.START = 1'b1; bus.DELAY = 16'd1; bus.WIDTH = 16'd7; bus.PERIOD = 16'd3; bus.COUNT = 16'd9;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (4) @(negedge clk);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (10) @(negedge clk);
    check_t1(k, "t4");

    // Reset during HIGH, with START and STOP also asserted.
    start_train(2, 4, 6, 0, k);
    repeat (2) @(negedge clk);
    r = 1'b1; bus.START = 1'b1; bus.STOP = 1'b1;
    @(negedge clk);
    r = 1'b0; bus.START = 1'b0; bus.STOP = 1'b0;
    check("t5_high_before_r", 64'(tr[k+2]), 64'({1'b1, 1'b1, 1'b0, 16'd1}));
    check("t5_after_r", 64'(tr[k+3]), 64'd0);

    // START and STOP together in IDLE: no start.
    @(negedge clk);
    k = edge_n + 1;
    bus.START = 1'b1; bus.STOP = 1'b1;
    repeat (3) @(negedge clk);
    bus.START = 1'b0; bus.STOP = 1'b0;
    check("t6_no_start_busy", mask(k, 3, 17), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.START = ($urandom_range(0, 3) == 0);
      bus.STOP  = ($urandom_range(0, 39) == 0);
      r         = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.DELAY  = CW'($urandom_range(0, 6));
        bus.WIDTH  = CW'($urandom_range(0, 5));
        bus.PERIOD = CW'($urandom_range(0, 10));
        bus.COUNT  = CW'($urandom_range(0, 4));
      end
    end
    @(negedge clk);
    bus.START = 1'b0; bus.STOP = 1'b0; r = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
